// File: rtl/spi_flash_read_arbiter.sv
// Shares one SPI flash port between instruction and data readers, issuing
// READ (0x03) word reads with round-robin arbitration and little-endian reassembly.
module spi_flash_read_arbiter #(
   parameter int CLK_DIV    = 1,
   parameter int DUMMY_CLKS = 1,
   parameter int CS_IDLE    = 2
) (
   input  logic        clk,
   input  logic        RESET,
   input  logic        i_req,
   input  logic [23:0] i_addr,
   output logic [31:0] i_rdata,
   output logic        i_rdy,
   input  logic        d_req,
   input  logic [23:0] d_addr,
   output logic [31:0] d_rdata,
   output logic        d_rdy,
   output logic        busy,
   output logic        spi_cs_n,
   output logic        spi_clk,
   output logic        spi_mosi,
   input  logic        spi_miso
);
   typedef enum logic [2:0] {IDLE, SHIFT_OUT, DUMMY, SHIFT_IN, DONE, GAP} state_t;

   localparam logic [15:0] DIV_LAST   = 16'(CLK_DIV - 1);
   localparam logic [5:0]  DUMMY_LAST = 6'(DUMMY_CLKS - 1);
   localparam logic [7:0]  GAP_LAST   = 8'(CS_IDLE - 1);

   state_t      state, state_next;
   logic [15:0] div_cnt;
   logic        phase_high;
   logic [5:0]  bit_cnt;
   logic [7:0]  gap_cnt;
   logic [30:0] tx_shift;
   logic [30:0] rx_shift;
   logic        gnt_d;
   logic        prefer_d;

   logic        grant;
   logic        pick_d;
   logic        period_end;
   logic [31:0] load_word;
   logic [31:0] rx_word;
   logic [31:0] rx_swapped;

   // tx_shift holds only the bits still to send; the current bit already sits on spi_mosi
   always_comb begin
      pick_d     = d_req && (!i_req || prefer_d);
      grant      = (state == IDLE) && (i_req || d_req);
      load_word  = {8'h03, (pick_d ? d_addr : i_addr) & 24'hFFFFFC};
      period_end = phase_high && (div_cnt == DIV_LAST);
      rx_word    = {rx_shift, spi_miso};
      rx_swapped = {rx_word[7:0], rx_word[15:8], rx_word[23:16], rx_word[31:24]};
      busy       = (state != IDLE) || grant;
   end

   always_ff @(posedge clk or negedge RESET) begin
      if (!RESET) state <= IDLE;
      else        state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:      if (grant) state_next = SHIFT_OUT;
         SHIFT_OUT: if (period_end && bit_cnt == 6'd31)
                       state_next = (DUMMY_CLKS == 0) ? SHIFT_IN : DUMMY;
         DUMMY:     if (period_end && bit_cnt == DUMMY_LAST) state_next = SHIFT_IN;
         SHIFT_IN:  if (period_end && bit_cnt == 6'd31) state_next = DONE;
         DONE:      state_next = GAP;
         GAP:       if (gap_cnt == GAP_LAST) state_next = IDLE;
         default:   state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge RESET) begin
      if (!RESET) begin
         div_cnt    <= '0;
         phase_high <= 1'b0;
         bit_cnt    <= '0;
         gap_cnt    <= '0;
         tx_shift   <= '0;
         rx_shift   <= '0;
         gnt_d      <= 1'b0;
         prefer_d   <= 1'b0;
         i_rdata    <= '0;
         d_rdata    <= '0;
         i_rdy      <= 1'b0;
         d_rdy      <= 1'b0;
         spi_cs_n   <= 1'b1;
         spi_clk    <= 1'b0;
         spi_mosi   <= 1'b0;
      end else begin
         i_rdy <= 1'b0;
         d_rdy <= 1'b0;
         case (state)
            IDLE: if (grant) begin
               gnt_d      <= pick_d;
               prefer_d   <= !pick_d;
               tx_shift   <= load_word[30:0];
               spi_mosi   <= load_word[31];
               spi_cs_n   <= 1'b0;
               spi_clk    <= 1'b0;
               phase_high <= 1'b0;
               div_cnt    <= '0;
               bit_cnt    <= '0;
            end
            SHIFT_OUT, DUMMY, SHIFT_IN: begin
               if (div_cnt == DIV_LAST) begin
                  div_cnt    <= '0;
                  phase_high <= !phase_high;
                  spi_clk    <= !phase_high;
               end else begin
                  div_cnt <= div_cnt + 16'd1;
               end
               // every per-bit action happens on the falling boundary that closes a period
               if (period_end) begin
                  bit_cnt <= (state_next == state) ? bit_cnt + 6'd1 : 6'd0;
                  if (state == SHIFT_OUT) begin
                     tx_shift <= {tx_shift[29:0], 1'b0};
                     spi_mosi <= (state_next == SHIFT_OUT) ? tx_shift[30] : 1'b0;
                  end
                  if (state == SHIFT_IN) begin
                     rx_shift <= rx_word[30:0];
                     if (state_next == DONE) begin
                        spi_cs_n <= 1'b1;
                        if (gnt_d) begin
                           d_rdata <= rx_swapped;
                           d_rdy   <= 1'b1;
                        end else begin
                           i_rdata <= rx_swapped;
                           i_rdy   <= 1'b1;
                        end
                     end
                  end
               end
            end
            DONE:    gap_cnt <= '0;
            GAP:     gap_cnt <= gap_cnt + 8'd1;
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_spi_flash_read_arbiter.sv
// Directed bench for spi_flash_read_arbiter: two DUTs (default timing and
// CLK_DIV=2/DUMMY_CLKS=0), each with its own behavioural READ-command flash.
module tb_spi_flash_read_arbiter;
   logic        clk = 1'b0;
   logic        RESET = 1'b1;
   logic        i_req_v  [2];
   logic [23:0] i_addr_v [2];
   logic        d_req_v  [2];
   logic [23:0] d_addr_v [2];
   int          cyc = 0;
   int          pass_cnt = 0;
   int          fail_cnt = 0;
   int          total_cnt = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [31:0] flash_word(input logic [3:0] idx);
      case (idx)
         4'd0:    return 32'h11223344;
         4'd1:    return 32'hCAFEF00D;
         4'd2:    return 32'h89ABCDEF;
         4'd3:    return 32'h13579BDF;
         4'd4:    return 32'h00500113;
         4'd5:    return 32'hDEADBEEF;
         4'd6:    return 32'h0BADC0DE;
         default: return 32'h5A5A5A5A ^ {28'h0, idx};
      endcase
   endfunction

   for (genvar g = 0; g < 2; g++) begin : g_bench
      localparam int DUM = (g == 0) ? 1 : 0;
      logic [31:0] i_rdata, d_rdata;
      logic        i_rdy, d_rdy, busy, cs_n, sclk, mosi;
      logic        miso = 1'b0;
      int          rises = 0;
      int          i_pulses = 0;
      int          d_pulses = 0;
      logic [31:0] cmd = '0;
      logic [31:0] stream = '0;
      logic [31:0] word;

      spi_flash_read_arbiter #(.CLK_DIV(g + 1), .DUMMY_CLKS(DUM), .CS_IDLE(2)) dut (
         .clk(clk), .RESET(RESET),
         .i_req(i_req_v[g]), .i_addr(i_addr_v[g]), .i_rdata(i_rdata), .i_rdy(i_rdy),
         .d_req(d_req_v[g]), .d_addr(d_addr_v[g]), .d_rdata(d_rdata), .d_rdy(d_rdy),
         .busy(busy), .spi_cs_n(cs_n), .spi_clk(sclk), .spi_mosi(mosi), .spi_miso(miso)
      );

      always @(posedge clk) begin
         if (i_rdy) i_pulses <= i_pulses + 1;
         if (d_rdy) d_pulses <= d_pulses + 1;
      end

      // flash captures command on rising spi_clk, drives data bytes in memory order on falling
      always @(posedge sclk or posedge cs_n) begin
         if (cs_n) begin
            rises = 0;
         end else begin
            if (rises < 32) cmd = {cmd[30:0], mosi};
            rises++;
            if (rises == 32) begin
               word   = flash_word(cmd[5:2]);
               stream = {word[7:0], word[15:8], word[23:16], word[31:24]};
            end
         end
      end

      always @(negedge sclk) begin
         if (!cs_n && rises >= 32 + DUM && rises < 64 + DUM)
            miso = stream[31 - (rises - 32 - DUM)];
      end
   end

   task automatic check_output(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
      total_cnt++;
      assert (observed === expected) begin
         pass_cnt++;
      end else begin
         fail_cnt++;
         $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
      end
   endtask

   task automatic wait_rdy(input int which, output logic seen);
      seen = 1'b0;
      for (int k = 0; k < 600 && !seen; k++) begin
         @(negedge clk);
         case (which)
            0:       seen = g_bench[0].i_rdy;
            1:       seen = g_bench[0].d_rdy;
            2:       seen = g_bench[0].i_rdy | g_bench[0].d_rdy;
            default: seen = g_bench[1].i_rdy;
         endcase
      end
   endtask

   initial begin
      logic       seen;
      int         t_start;
      int         hi;
      int         ip;
      logic [3:0] order;

      for (int k = 0; k < 2; k++) begin
         i_req_v[k]  = 1'b0;
         d_req_v[k]  = 1'b0;
         i_addr_v[k] = '0;
         d_addr_v[k] = '0;
      end
      #3 RESET = 1'b0;
      repeat (3) @(negedge clk);
      check_output("rst_cs_n",   32'(g_bench[0].cs_n),  32'd1);
      check_output("rst_sclk",   32'(g_bench[0].sclk),  32'd0);
      check_output("rst_mosi",   32'(g_bench[0].mosi),  32'd0);
      check_output("rst_i_rdy",  32'(g_bench[0].i_rdy), 32'd0);
      check_output("rst_d_rdy",  32'(g_bench[0].d_rdy), 32'd0);
      check_output("rst_i_data", g_bench[0].i_rdata,    32'h0);
      check_output("rst_d_data", g_bench[0].d_rdata,    32'h0);
      check_output("rst_busy",   32'(g_bench[0].busy),  32'd0);
      RESET = 1'b1;
      @(negedge clk);

      $display("[TB] single instruction read");
      i_addr_v[0] = 24'h000010;
      i_req_v[0]  = 1'b1;
      t_start     = cyc;
      wait_rdy(0, seen);
      check_output("i_latency", 32'(cyc - t_start), 32'd131);
      check_output("i_data",    g_bench[0].i_rdata, 32'h00500113);
      check_output("i_cmd",     g_bench[0].cmd,     32'h03000010);
      i_req_v[0] = 1'b0;
      @(negedge clk);
      check_output("i_rdy_one_cycle", 32'(g_bench[0].i_rdy), 32'd0);
      check_output("busy_in_gap",     32'(g_bench[0].busy),  32'd1);
      repeat (3) @(negedge clk);
      check_output("busy_after_gap",  32'(g_bench[0].busy),  32'd0);
      check_output("i_pulses_1",      32'(g_bench[0].i_pulses), 32'd1);
      check_output("d_pulses_0",      32'(g_bench[0].d_pulses), 32'd0);

      $display("[TB] unaligned data read");
      d_addr_v[0] = 24'h000013;
      d_req_v[0]  = 1'b1;
      t_start     = cyc;
      wait_rdy(1, seen);
      check_output("d_latency", 32'(cyc - t_start), 32'd131);
      check_output("d_data",    g_bench[0].d_rdata, 32'h00500113);
      check_output("d_cmd",     g_bench[0].cmd,     32'h03000010);
      d_req_v[0] = 1'b0;
      repeat (4) @(negedge clk);
      check_output("i_data_held", g_bench[0].i_rdata, 32'h00500113);
      check_output("d_pulses_1",  32'(g_bench[0].d_pulses), 32'd1);
      check_output("i_pulses_still_1", 32'(g_bench[0].i_pulses), 32'd1);

      $display("[TB] simultaneous requests after reset");
      RESET = 1'b0;
      @(negedge clk);
      check_output("rst_clears_i_data", g_bench[0].i_rdata, 32'h0);
      RESET = 1'b1;
      @(negedge clk);
      i_addr_v[0] = 24'h000000;
      d_addr_v[0] = 24'h000004;
      i_req_v[0]  = 1'b1;
      d_req_v[0]  = 1'b1;
      t_start     = cyc;
      wait_rdy(2, seen);
      check_output("sim_first_is_i", 32'(g_bench[0].i_rdy), 32'd1);
      check_output("sim_i_latency",  32'(cyc - t_start),    32'd131);
      check_output("sim_i_data",     g_bench[0].i_rdata,    32'h11223344);
      i_req_v[0] = 1'b0;
      hi = 0;
      while (g_bench[0].cs_n && hi < 20) begin
         hi++;
         @(negedge clk);
      end
      check_output("sim_cs_gap", 32'(hi >= 2), 32'd1);
      wait_rdy(1, seen);
      check_output("sim_d_latency", 32'(cyc - t_start), 32'd265);
      check_output("sim_d_data",    g_bench[0].d_rdata, 32'hCAFEF00D);
      check_output("sim_d_cmd",     g_bench[0].cmd,     32'h03000004);
      d_req_v[0] = 1'b0;
      repeat (4) @(negedge clk);

      $display("[TB] round-robin with both requests held");
      i_addr_v[0] = 24'h000008;
      d_addr_v[0] = 24'h00000C;
      i_req_v[0]  = 1'b1;
      d_req_v[0]  = 1'b1;
      order       = '0;
      for (int n = 0; n < 4; n++) begin
         wait_rdy(2, seen);
         order = {order[2:0], g_bench[0].d_rdy};
      end
      i_req_v[0] = 1'b0;
      d_req_v[0] = 1'b0;
      check_output("rr_order",  32'(order),          32'h5);
      check_output("rr_i_data", g_bench[0].i_rdata, 32'h89ABCDEF);
      check_output("rr_d_data", g_bench[0].d_rdata, 32'h13579BDF);

      $display("[TB] CLK_DIV=2 DUMMY_CLKS=0 instance");
      i_addr_v[1] = 24'h000014;
      i_req_v[1]  = 1'b1;
      t_start     = cyc;
      wait_rdy(3, seen);
      check_output("div2_latency", 32'(cyc - t_start), 32'd257);
      check_output("div2_data",    g_bench[1].i_rdata, 32'hDEADBEEF);
      check_output("div2_cmd",     g_bench[1].cmd,     32'h03000014);
      check_output("div2_d_data",  g_bench[1].d_rdata, 32'h0);
      i_req_v[1] = 1'b0;
      @(negedge clk);
      check_output("div2_busy_gap", 32'(g_bench[1].busy), 32'd1);
      repeat (6) @(negedge clk);

      $display("[TB] reset in the middle of a read");
      i_addr_v[0] = 24'h000018;
      i_req_v[0]  = 1'b1;
      ip          = g_bench[0].i_pulses;
      repeat (40) @(negedge clk);
      check_output("mid_cs_active", 32'(g_bench[0].cs_n), 32'd0);
      check_output("mid_sclk_high", 32'(g_bench[0].sclk), 32'd1);
      i_req_v[0] = 1'b0;
      RESET      = 1'b0;
      #1;
      check_output("abort_cs_n", 32'(g_bench[0].cs_n), 32'd1);
      check_output("abort_sclk", 32'(g_bench[0].sclk), 32'd0);
      check_output("abort_busy", 32'(g_bench[0].busy), 32'd0);
      repeat (5) @(negedge clk);
      RESET = 1'b1;
      repeat (2) @(negedge clk);
      check_output("abort_no_rdy", 32'(g_bench[0].i_pulses), 32'(ip));
      i_req_v[0] = 1'b1;
      t_start    = cyc;
      wait_rdy(0, seen);
      check_output("post_rst_latency", 32'(cyc - t_start), 32'd131);
      check_output("post_rst_data",    g_bench[0].i_rdata, 32'h0BADC0DE);
      i_req_v[0] = 1'b0;
      repeat (3) @(negedge clk);
      check_output("post_rst_pulses", 32'(g_bench[0].i_pulses), 32'(ip + 1));

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end
endmodule
